// File: rtl/id_scoreboard.sv
// Decode-stage hazard tracker: shadows DEPTH in-flight writers, picks forwarding stage per source, raises load-use stall.
// stall_req is combinational from ID inputs and tracker state; forwarding selects land one cycle later with the instruction in EX; pipe_freeze holds all state.
module id_scoreboard #(
  parameter int REGID_W    = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = DEPTH,
  parameter int FWD_W      = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic               id_rs1_read,
  input  logic               id_rs2_read,
  input  logic [REGID_W-1:0] id_rs1_regid,
  input  logic [REGID_W-1:0] id_rs2_regid,
  input  logic               id_reg_write,
  input  logic [REGID_W-1:0] id_reg_regid,
  input  logic               id_mem_read,
  input  logic               id_flush,
  input  logic [DEPTH-1:0]   kill_mask,
  input  logic               pipe_freeze,
  output logic               stall_req,
  output logic [FWD_W-1:0]   ex_fwd_sel_rs1,
  output logic [FWD_W-1:0]   ex_fwd_sel_rs2,
  output logic [CNT_W-1:0]   pending_load_cnt
);

  typedef struct packed {
    logic               vld;
    logic               ld;
    logic [REGID_W-1:0] regid;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [FWD_W-1:0] sel_q [2];
  logic [FWD_W-1:0] sel_d [2];

  logic [1:0]         src_rd;
  logic [REGID_W-1:0] src_id [2];
  logic [FWD_W-1:0]   code [2];
  logic [1:0]         haz;
  logic               issue;
  logic               alloc;
  logic [CNT_W-1:0]   load_cnt;

  assign src_rd    = {id_rs2_read, id_rs1_read};
  assign src_id[0] = id_rs1_regid;
  assign src_id[1] = id_rs2_regid;

  // Scan oldest to youngest so the youngest match overwrites; code is the producer's stage once the consumer reaches EX.
  always_comb begin
    code[0] = '0;
    code[1] = '0;
    haz     = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_q[k].vld && src_rd[s] && (src_id[s] != '0) && (src_id[s] == ent_q[k].regid)) begin
          code[s] = (k + 1 < DEPTH) ? FWD_W'(k + 1) : '0;
          haz[s]  = ent_q[k].ld && (k + 1 < LOAD_READY);
        end
      end
    end
  end

  assign stall_req = id_valid & ~id_flush & (|haz);
  assign issue     = id_valid & ~id_flush & ~stall_req;
  assign alloc     = issue & id_reg_write & (id_reg_regid != '0);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_d[k]     = ent_q[k];
      ent_d[k].vld = ent_q[k].vld & ~kill_mask[k];
    end
    sel_d[0] = sel_q[0];
    sel_d[1] = sel_q[1];
    if (!pipe_freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_d[k]     = ent_q[k-1];
        ent_d[k].vld = ent_q[k-1].vld & ~kill_mask[k-1];
      end
      ent_d[0].vld   = alloc;
      ent_d[0].ld    = id_mem_read;
      ent_d[0].regid = id_reg_regid;
      sel_d[0]       = issue ? code[0] : '0;
      sel_d[1]       = issue ? code[1] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_q[k] <= '0;
      end
      sel_q[0] <= '0;
      sel_q[1] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_q[k] <= ent_d[k];
      end
      sel_q[0] <= sel_d[0];
      sel_q[1] <= sel_d[1];
    end
  end

  always_comb begin
    load_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      load_cnt = load_cnt + CNT_W'(ent_q[k].vld & ent_q[k].ld);
    end
  end

  assign ex_fwd_sel_rs1   = sel_q[0];
  assign ex_fwd_sel_rs2   = sel_q[1];
  assign pending_load_cnt = load_cnt;

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: two instances (LOAD_READY 3 and 2) share stimulus; directed scenarios then random traffic vs a reference model.
module tb_id_scoreboard;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_read, id_rs2_read, id_reg_write, id_mem_read, id_flush, pipe_freeze;
  logic [4:0] id_rs1_regid, id_rs2_regid, id_reg_regid;
  logic [2:0] kill_mask;
  logic       stall_a, stall_b;
  logic [1:0] s1a, s2a, s1b, s2b, ca, cb;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  id_scoreboard #(.REGID_W(5), .DEPTH(D), .LOAD_READY(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .id_rs1_regid(id_rs1_regid), .id_rs2_regid(id_rs2_regid),
    .id_reg_write(id_reg_write), .id_reg_regid(id_reg_regid),
    .id_mem_read(id_mem_read), .id_flush(id_flush), .kill_mask(kill_mask),
    .pipe_freeze(pipe_freeze), .stall_req(stall_a),
    .ex_fwd_sel_rs1(s1a), .ex_fwd_sel_rs2(s2a), .pending_load_cnt(ca)
  );

  id_scoreboard #(.REGID_W(5), .DEPTH(D), .LOAD_READY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .id_rs1_regid(id_rs1_regid), .id_rs2_regid(id_rs2_regid),
    .id_reg_write(id_reg_write), .id_reg_regid(id_reg_regid),
    .id_mem_read(id_mem_read), .id_flush(id_flush), .kill_mask(kill_mask),
    .pipe_freeze(pipe_freeze), .stall_req(stall_b),
    .ex_fwd_sel_rs1(s1b), .ex_fwd_sel_rs2(s2b), .pending_load_cnt(cb)
  );

  // Reference model: per instance, list of in-flight writers indexed by stage after ID.
  int         lr [2] = '{3, 2};
  bit         m_vld [2][D];
  bit         m_ld  [2][D];
  logic [4:0] m_rid [2][D];
  int         m_s1 [2];
  int         m_s2 [2];

  function automatic int youngest(int i, bit rd, logic [4:0] rs);
    if (!rd || rs == 0) return -1;
    for (int k = 0; k < D; k++)
      if (m_vld[i][k] && m_rid[i][k] == rs) return k;
    return -1;
  endfunction

  // Producer will sit one stage further when the consumer is in EX; gone past WB means regfile.
  function automatic int sel_of(int k);
    if (k < 0) return 0;
    return (k + 1 < D) ? k + 1 : 0;
  endfunction

  function automatic bit haz_of(int i, int k);
    if (k < 0) return 1'b0;
    return m_ld[i][k] && (k + 1 < lr[i]);
  endfunction

  function automatic bit m_stall(int i);
    return id_valid && !id_flush &&
           (haz_of(i, youngest(i, id_rs1_read, id_rs1_regid)) ||
            haz_of(i, youngest(i, id_rs2_read, id_rs2_regid)));
  endfunction

  function automatic int m_cnt(int i);
    int c = 0;
    for (int k = 0; k < D; k++) c += (m_vld[i][k] && m_ld[i][k]) ? 1 : 0;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drv(input bit v, input bit a, input logic [4:0] ra, input bit b, input logic [4:0] rb,
                     input bit w, input logic [4:0] d, input bit m,
                     input bit f = 1'b0, input logic [2:0] km = 3'b000, input bit fz = 1'b0);
    id_valid = v; id_rs1_read = a; id_rs1_regid = ra; id_rs2_read = b; id_rs2_regid = rb;
    id_reg_write = w; id_reg_regid = d; id_mem_read = m;
    id_flush = f; kill_mask = km; pipe_freeze = fz;
    #1;
  endtask

  // Called just after a falling edge with inputs settled: checks stall, advances one clock, checks registered outputs.
  task automatic tick();
    bit         nv [2][D];
    bit         nl [2][D];
    logic [4:0] nr [2][D];
    int         n1 [2];
    int         n2 [2];
    chk("stall_a", stall_a, m_stall(0));
    chk("stall_b", stall_b, m_stall(1));
    for (int i = 0; i < 2; i++) begin
      bit st, iss;
      int k1, k2;
      st  = m_stall(i);
      k1  = youngest(i, id_rs1_read, id_rs1_regid);
      k2  = youngest(i, id_rs2_read, id_rs2_regid);
      iss = id_valid && !id_flush && !st;
      for (int k = 0; k < D; k++) begin
        nv[i][k] = m_vld[i][k]; nl[i][k] = m_ld[i][k]; nr[i][k] = m_rid[i][k];
      end
      n1[i] = m_s1[i]; n2[i] = m_s2[i];
      if (!rst_n) begin
        for (int k = 0; k < D; k++) nv[i][k] = 1'b0;
        n1[i] = 0; n2[i] = 0;
      end else if (pipe_freeze) begin
        for (int k = 0; k < D; k++) nv[i][k] = m_vld[i][k] && !kill_mask[k];
      end else begin
        for (int k = D - 1; k >= 1; k--) begin
          nv[i][k] = m_vld[i][k-1] && !kill_mask[k-1];
          nl[i][k] = m_ld[i][k-1];
          nr[i][k] = m_rid[i][k-1];
        end
        nv[i][0] = iss && id_reg_write && id_reg_regid != 0;
        nl[i][0] = id_mem_read;
        nr[i][0] = id_reg_regid;
        n1[i] = iss ? sel_of(k1) : 0;
        n2[i] = iss ? sel_of(k2) : 0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < D; k++) begin
        m_vld[i][k] = nv[i][k]; m_ld[i][k] = nl[i][k]; m_rid[i][k] = nr[i][k];
      end
      m_s1[i] = n1[i]; m_s2[i] = n2[i];
    end
    chk("sel1_a", s1a, m_s1[0]);
    chk("sel2_a", s2a, m_s2[0]);
    chk("cnt_a",  ca,  m_cnt(0));
    chk("sel1_b", s1b, m_s1[1]);
    chk("sel2_b", s2b, m_s2[1]);
    chk("cnt_b",  cb,  m_cnt(1));
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < D; k++) begin
        m_vld[i][k] = 1'b0; m_ld[i][k] = 1'b0; m_rid[i][k] = '0;
      end
      m_s1[i] = 0; m_s2[i] = 0;
    end
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    drv(1, 1, 7, 1, 7, 1, 8, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_sel1", s1a, 0);
    chk("rst_sel2_b", s2b, 0);
    chk("rst_cnt", ca, 0);
    rst_n = 1'b1;
    drain(3);

    // ALU chain: adjacent, one between, two between
    drv(1, 0, 0, 0, 0, 1, 5, 0); tick();
    drv(1, 1, 5, 0, 0, 1, 6, 0);
    chk("alu_adj_stall", stall_a, 0);
    tick();
    chk("alu_adj_sel", s1a, 1);
    drain(3);
    drv(1, 0, 0, 0, 0, 1, 5, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 9, 0); tick();
    drv(1, 1, 5, 0, 0, 1, 6, 0); tick();
    chk("alu_gap1_sel", s1a, 2);
    drain(3);
    drv(1, 0, 0, 0, 0, 1, 5, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 9, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 10, 0); tick();
    drv(1, 1, 5, 0, 0, 1, 6, 0);
    chk("alu_gap2_stall", stall_a, 0);
    tick();
    chk("alu_gap2_sel", s1a, 0);
    drain(3);

    // Load-use: lw x7 ; add x8,x7,x7
    drv(1, 0, 0, 0, 0, 1, 7, 1); tick();
    chk("lu_cnt_load", ca, 1);
    drv(1, 1, 7, 1, 7, 1, 8, 0);
    chk("lu_stall1_a", stall_a, 1);
    chk("lu_stall1_b", stall_b, 1);
    tick();
    chk("lu_stall2_a", stall_a, 1);
    chk("lu_stall2_b", stall_b, 0);
    tick();
    chk("lu_sel1_b", s1b, 2);
    chk("lu_sel2_b", s2b, 2);
    chk("lu_stall3_a", stall_a, 0);
    chk("lu_cnt_pre", ca, 1);
    tick();
    chk("lu_sel1_a", s1a, 0);
    chk("lu_sel2_a", s2a, 0);
    chk("lu_cnt_post", ca, 0);
    drain(3);

    // Priority: add x5 ; lw x5 ; consumer x5 -> younger load wins
    drv(1, 0, 0, 0, 0, 1, 5, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 5, 1); tick();
    drv(1, 1, 5, 0, 0, 1, 11, 0);
    chk("pri_stall1_a", stall_a, 1);
    chk("pri_stall1_b", stall_b, 1);
    tick();
    chk("pri_stall2_a", stall_a, 1);
    chk("pri_stall2_b", stall_b, 0);
    tick();
    chk("pri_sel_b", s1b, 2);
    chk("pri_stall3_a", stall_a, 0);
    tick();
    chk("pri_sel_a", s1a, 0);
    drain(3);

    // x0 writer and read-bit gating
    drv(1, 0, 0, 0, 0, 1, 0, 1); tick();
    chk("x0_cnt", ca, 0);
    drv(1, 1, 0, 1, 0, 1, 12, 0);
    chk("x0_stall", stall_a, 0);
    tick();
    chk("x0_sel1", s1a, 0);
    drain(3);
    drv(1, 0, 0, 0, 0, 1, 3, 1); tick();
    drv(1, 1, 4, 0, 3, 1, 13, 0);
    chk("rb_stall", stall_a, 0);
    tick();
    chk("rb_sel2", s2a, 0);
    chk("rb_sel1", s1a, 0);
    drain(3);

    // Flush + kill of the load in EX
    drv(1, 0, 0, 0, 0, 1, 7, 1); tick();
    drv(1, 1, 7, 1, 7, 1, 8, 0, 1, 3'b001);
    chk("fk_stall_a", stall_a, 0);
    chk("fk_stall_b", stall_b, 0);
    tick();
    chk("fk_cnt", ca, 0);
    chk("fk_sel1", s1a, 0);
    drv(1, 1, 7, 1, 7, 1, 8, 0);
    chk("fk_next_stall", stall_a, 0);
    tick();
    drain(3);

    // Kill without flush still stalls that cycle, clean the next
    drv(1, 0, 0, 0, 0, 1, 7, 1); tick();
    drv(1, 1, 7, 0, 0, 1, 8, 0, 0, 3'b001);
    chk("kn_stall1", stall_a, 1);
    tick();
    drv(1, 1, 7, 0, 0, 1, 8, 0);
    chk("kn_stall2", stall_a, 0);
    chk("kn_cnt", ca, 0);
    tick();
    drain(3);

    // Freeze for 3 cycles during a load stall
    drv(1, 0, 0, 0, 0, 1, 5, 0); tick();
    drv(1, 1, 5, 0, 0, 1, 7, 1); tick();
    chk("fz_pre_sel", s1a, 1);
    repeat (3) begin
      drv(1, 1, 7, 1, 7, 1, 8, 0, 0, 3'b000, 1);
      chk("fz_stall", stall_a, 1);
      tick();
      chk("fz_sel_hold", s1a, 1);
      chk("fz_cnt_hold", ca, 1);
    end
    drv(1, 1, 7, 1, 7, 1, 8, 0);
    chk("fzr_stall1", stall_a, 1);
    tick();
    chk("fzr_sel", s1a, 0);
    chk("fzr_stall2", stall_a, 1);
    tick();
    chk("fzr_stall3", stall_a, 0);
    tick();
    drain(3);

    // Reset mid-stall
    drv(1, 0, 0, 0, 0, 1, 7, 1); tick();
    drv(1, 1, 7, 1, 7, 1, 8, 0);
    chk("rm_stall", stall_a, 1);
    rst_n = 1'b0;
    tick();
    chk("rm_sel1", s1a, 0);
    chk("rm_cnt_a", ca, 0);
    chk("rm_cnt_b", cb, 0);
    rst_n = 1'b1;
    #1;
    chk("rm_rel_stall_a", stall_a, 0);
    chk("rm_rel_stall_b", stall_b, 0);
    tick();
    drain(3);

    // Random traffic against the model
    repeat (1500) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drv($urandom_range(0, 9) < 8, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
          $urandom_range(0, 1), 5'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
          $urandom_range(0, 11) == 0,
          {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0},
          $urandom_range(0, 9) == 0);
      tick();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
